mul_sched: RTL

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_if.sv | 28 ++
 rtl/mul_sched.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mul_sched_if.sv
// Request/grant bus for the two-requester shift-add multiplier.
// Handshake: a requester holds reqN high with aN/bN stable; gntN is a one-cycle
// combinational grant and the operands are captured on the rising edge ending that cycle.
interface mul_sched_if;
   logic       req0;
   logic [4:0] a0;
   logic [4:0] b0;
   logic       req1;
   logic [4:0] a1;
   logic [4:0] b1;
   logic       gnt0;
   logic       gnt1;
   logic       busy;
   logic       done;
   logic       done_id;
   logic [9:0] mulout;
   logic [1:0] state_dbg;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, busy, done, done_id, mulout, state_dbg
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, busy, done, done_id, mulout, state_dbg
   );
endinterface

// File: rtl/mul_sched.sv
// Round-robin shared 5x5 unsigned multiplier: one shift-add step per cycle,
// with early termination when either latched operand is zero.
module mul_sched (
   input  logic         clk,
   input  logic         rst_n,
   mul_sched_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] a_q, a_d;
   logic [4:0] b_q, b_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [9:0] acc_q, acc_d;
   logic [9:0] mul_q, mul_d;
   logic [2:0] step_q, step_d;
   logic       done_q, done_d;
   logic       done_id_q, done_id_d;
   logic       busy_q, busy_d;

   logic       win;
   logic       grant_ok;
   logic [4:0] win_a;
   logic [4:0] win_b;
   logic [9:0] addend;

   // With both requesting, the one not served last wins; a lone requester always wins.
   always_comb begin
      win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
      grant_ok = (state_q == IDLE) && rst_n && (bus.req0 || bus.req1);
      win_a    = win ? bus.a1 : bus.a0;
      win_b    = win ? bus.b1 : bus.b0;
      addend   = b_q[step_q] ? ({5'd0, a_q} << step_q) : 10'd0;
   end

   assign bus.gnt0      = grant_ok && !win;
   assign bus.gnt1      = grant_ok && win;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.mulout    = mul_q;
   assign bus.state_dbg = state_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      owner_d   = owner_q;
      last_d    = last_q;
      acc_d     = acc_q;
      mul_d     = mul_q;
      step_d    = step_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      case (state_q)
         IDLE: begin
            if (grant_ok) begin
               a_d     = win_a;
               b_d     = win_b;
               owner_d = win;
               last_d  = win;
               acc_d   = 10'd0;
               step_d  = 3'd0;
               if (win_a == 5'd0 || win_b == 5'd0) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  done_id_d = win;
                  mul_d     = 10'd0;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d  = acc_q + addend;
            step_d = step_q + 3'd1;
            if (step_q == 3'd4) begin
               state_d   = DONE;
               done_d    = 1'b1;
               done_id_d = owner_q;
               mul_d     = acc_q + addend;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= 5'd0;
         b_q       <= 5'd0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         acc_q     <= 10'd0;
         mul_q     <= 10'd0;
         step_q    <= 3'd0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         acc_q     <= acc_d;
         mul_q     <= mul_d;
         step_q    <= step_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         busy_q    <= busy_d;
      end
   end
endmodule
